rv_multicycle_seq: RTL and testbench

- PC/IR/state sequencer for the multi-cycle RV32I core. It is the successor to the single-cycle top-level.
- Replaces split IMEM/DMEM with one shared memory port under a req/ready handshake, so each instruction takes a variable number of cycles.
- Owns PC, IR, the ALU-out and MDR latches, trap detection and the performance counters.
- The external datapath (register file, immediate generator, ALU, branch comparator) computes alu_result, pc_target and take_branch from ir and the register values.

---
 rtl/rv_multicycle_seq_if.sv | 11 +
 rtl/rv_multicycle_seq.sv | 85 ++++++++
 tb/tb_rv_multicycle_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rv_multicycle_seq_if.sv
// rv_multicycle_seq_if: shared memory port (req/ready handshake; master drives req/we/addr/wdata, slave returns rdata/ready)
interface rv_multicycle_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/rv_multicycle_seq.sv
// rv_multicycle_seq: multi-cycle RV32I PC/IR/state sequencer (clk/rst, bus=shared mem port, datapath results in, pc/ir/alu_out/mdr/rf_we/halt/trap_cause/counters out)
module rv_multicycle_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  rv_multicycle_seq_if.master bus,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      store_data,
  input  logic [31:0]      pc_target,
  input  logic             take_branch,
  output logic [31:0]      pc,
  output logic [31:0]      ir,
  output logic [31:0]      alu_out,
  output logic [31:0]      mdr,
  output logic             rf_we,
  output logic             halt,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [31:0] TO = MEM_TIMEOUT;
  state_t state, state_nxt;
  logic [31:0] wait_cnt, pc_nxt;
  logic [6:0] op;
  logic is_load, is_store, is_branch, is_jump, legal, timeout, retire;
  assign op = ir[6:0];
  assign is_load = op == 7'b0000011;
  assign is_store = op == 7'b0100011;
  assign is_branch = op == 7'b1100011;
  assign is_jump = op == 7'b1101111 || op == 7'b1100111;
  assign legal = is_load || is_store || is_branch || is_jump || op == 7'b0110011 ||
                 op == 7'b0010011 || op == 7'b0110111 || op == 7'b0010111;
  assign timeout = TO != 32'd0 && bus.mem_req && !bus.mem_ready && wait_cnt == TO - 32'd1;
  assign retire = (state == EXEC && is_branch) || (state == MEM && is_store && bus.mem_ready) || state == WB;
  assign pc_nxt = ((is_branch || is_jump) && take_branch) ? pc_target : pc + 32'd4;
  assign bus.mem_wdata = store_data;
  always_comb begin
    bus.mem_req = state == FETCH || state == MEM;
    bus.mem_we = state == MEM && is_store;
    bus.mem_addr = state == MEM ? alu_out : pc;
    rf_we = state == WB;
    halt = state == TRAP;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   state_nxt = timeout ? TRAP : bus.mem_ready ? DECODE : FETCH;
      DECODE:  state_nxt = legal ? EXEC : TRAP;
      EXEC:    state_nxt = (is_load || is_store) ? MEM : WB;
      MEM:     state_nxt = timeout ? TRAP : bus.mem_ready ? WB : MEM;
      WB:      state_nxt = FETCH;
      default: state_nxt = TRAP;
    endcase
    if (retire) state_nxt = pc_nxt[1:0] != 2'b00 ? TRAP : FETCH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      alu_out <= '0;
      mdr <= '0;
      cycle_cnt <= '0;
      instret_cnt <= '0;
      trap_cause <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      wait_cnt <= (bus.mem_req && !bus.mem_ready) ? wait_cnt + 32'd1 : 32'd0;
      if (state == FETCH && bus.mem_ready) ir <= bus.mem_rdata;
      if (state == EXEC) alu_out <= alu_result;
      if (state == MEM && is_load && bus.mem_ready) mdr <= bus.mem_rdata;
      if (retire) begin
        pc <= pc_nxt;
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
      if (state_nxt == TRAP && state != TRAP)
        trap_cause <= state == DECODE ? 2'd1 : timeout ? 2'd2 : 2'd3;
    end
  end
endmodule

// File: tb/tb_rv_multicycle_seq.sv
// tb_rv_multicycle_seq: directed self-checking bench for rv_multicycle_seq
module tb_rv_multicycle_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] alu_result, store_data, pc_target;
  logic take_branch;
  logic [31:0] pc, ir, alu_out, mdr;
  logic rf_we, halt;
  logic [1:0] trap_cause;
  logic [31:0] cycle_cnt, instret_cnt;
  int n_checks = 0;
  int n_fail = 0;
  rv_multicycle_seq_if bus();
  rv_multicycle_seq #(.RESET_PC(32'h0), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_result(alu_result), .store_data(store_data), .pc_target(pc_target), .take_branch(take_branch),
    .pc(pc), .ir(ir), .alu_out(alu_out), .mdr(mdr), .rf_we(rf_we), .halt(halt),
    .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    alu_result = 32'd5;
    store_data = 32'h0;
    pc_target = 32'h0;
    take_branch = 1'b0;
    step();
    step();
    check("rst_pc", pc, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_halt", halt, 0);
    check("rst_cyc", cycle_cnt, 0);
    check("rst_inst", instret_cnt, 0);
    check("rst_ir", ir, 0);
    check("rst_cause", trap_cause, 0);
    rst = 1'b0;
    step();
    check("f_req", bus.mem_req, 1);
    check("f_addr", bus.mem_addr, 0);
    check("f_we", bus.mem_we, 0);
    step();
    check("d_ir", ir, 32'h0050_0093);
    check("d_req", bus.mem_req, 0);
    step();
    check("x_rfwe", rf_we, 0);
    step();
    check("wb_rfwe", rf_we, 1);
    bus.mem_rdata = 32'h0000_2083;
    step();
    check("addi_pc", pc, 32'h4);
    check("addi_inst", instret_cnt, 1);
    check("addi_cyc", cycle_cnt, 5);
    check("addi_rfwe_off", rf_we, 0);
    check("addi_next_req", bus.mem_req, 1);
    step();
    check("lw_ir", ir, 32'h0000_2083);
    bus.mem_ready = 1'b0;
    alu_result = 32'h100;
    step();
    step();
    check("lw_aluout", alu_out, 32'h100);
    check("lw_req", bus.mem_req, 1);
    check("lw_addr", bus.mem_addr, 32'h100);
    check("lw_we", bus.mem_we, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lw_hold_addr", bus.mem_addr, 32'h100);
      check("lw_hold_req", bus.mem_req, 1);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    check("lw_mdr", mdr, 32'hDEAD_BEEF);
    check("lw_rfwe", rf_we, 1);
    bus.mem_rdata = 32'h0000_0063;
    take_branch = 1'b1;
    pc_target = 32'h40;
    step();
    check("lw_pc", pc, 32'h8);
    check("lw_inst", instret_cnt, 2);
    check("lw_cyc", cycle_cnt, 13);
    check("lw_rfwe_off", rf_we, 0);
    step();
    check("beq_d_rfwe", rf_we, 0);
    step();
    check("beq_x_rfwe", rf_we, 0);
    step();
    check("beq_t_pc", pc, 32'h40);
    check("beq_t_inst", instret_cnt, 3);
    check("beq_t_addr", bus.mem_addr, 32'h40);
    check("beq_t_rfwe", rf_we, 0);
    take_branch = 1'b0;
    step();
    step();
    step();
    check("beq_nt_pc", pc, 32'h44);
    check("beq_nt_inst", instret_cnt, 4);
    bus.mem_rdata = 32'h0000_00E7;
    take_branch = 1'b1;
    pc_target = 32'h42;
    step();
    step();
    step();
    check("jalr_rfwe", rf_we, 1);
    step();
    check("mis_halt", halt, 1);
    check("mis_cause", trap_cause, 3);
    check("mis_pc", pc, 32'h42);
    check("mis_inst", instret_cnt, 5);
    check("mis_cyc", cycle_cnt, 23);
    step();
    step();
    step();
    check("mis_cyc_frozen", cycle_cnt, 23);
    check("mis_req", bus.mem_req, 0);
    check("mis_halt_hold", halt, 1);
    take_branch = 1'b0;
    bus.mem_rdata = 32'hFFFF_FFFF;
    do_reset();
    check("ill_rst_halt", halt, 0);
    check("ill_rst_cause", trap_cause, 0);
    step();
    step();
    step();
    check("ill_halt", halt, 1);
    check("ill_cause", trap_cause, 1);
    check("ill_pc", pc, 0);
    check("ill_inst", instret_cnt, 0);
    check("ill_cyc", cycle_cnt, 3);
    step();
    step();
    step();
    check("ill_cyc_frozen", cycle_cnt, 3);
    check("ill_req", bus.mem_req, 0);
    bus.mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check("to_pre_halt", halt, 0);
    check("to_pre_req", bus.mem_req, 1);
    step();
    check("to_halt", halt, 1);
    check("to_cause", trap_cause, 2);
    step();
    check("to_req", bus.mem_req, 0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0010_2023;
    alu_result = 32'h200;
    store_data = 32'hCAFE_F00D;
    do_reset();
    step();
    step();
    step();
    step();
    check("sw_we", bus.mem_we, 1);
    check("sw_addr", bus.mem_addr, 32'h200);
    check("sw_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    step();
    check("sw_pc", pc, 32'h4);
    check("sw_inst", instret_cnt, 1);
    check("sw_cyc", cycle_cnt, 5);
    check("sw_fetch_we", bus.mem_we, 0);
    step();
    step();
    step();
    check("sw2_we", bus.mem_we, 1);
    rst = 1'b1;
    step();
    check("abort_req", bus.mem_req, 0);
    check("abort_we", bus.mem_we, 0);
    check("abort_pc", pc, 0);
    check("abort_cyc", cycle_cnt, 0);
    check("abort_inst", instret_cnt, 0);
    rst = 1'b0;
    bus.mem_rdata = 32'h0050_0093;
    step();
    check("restart_req", bus.mem_req, 1);
    check("restart_addr", bus.mem_addr, 0);
    check("restart_cyc", cycle_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
